// File: rtl/spi_pkg.sv
// Shared constants and types for the SPI responder.
`timescale 1ns/1ps
package spi_pkg;

  localparam int unsigned FRAME_W = 12;
  localparam int unsigned CNT_W   = 4;

  localparam logic [FRAME_W-1:0] IDLE_WORD_DEF = 12'h000;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    HOLD
  } state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer with rising/falling edge pulses on the synchronized level.
`timescale 1ns/1ps
module spi_sync_edge #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic sync_o,
  output logic rise_c,
  output logic fall_c
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign sync_o = sync_q[STAGES-1];
  assign rise_c = sync_o & ~prev_q;
  assign fall_c = ~sync_o & prev_q;

endmodule

// File: rtl/spi_responder.sv
// 12-bit LSB-first SPI responder (mode 0) with a one-word tx holding buffer.
// Optional sticky tx underrun flag enabled by SPI_RESPONDER_UNDERRUN_EN.
`timescale 1ns/1ps
module spi_responder
  import spi_pkg::*;
#(
  parameter int unsigned         SYNC_STAGES = 2,
  parameter logic [FRAME_W-1:0]  IDLE_WORD   = IDLE_WORD_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sclk,
  input  logic               cs,
  input  logic               mosi,
  output logic               miso,
  input  logic [FRAME_W-1:0] tx_data,
  input  logic               tx_valid,
  output logic               tx_ready,
  output logic [FRAME_W-1:0] rx_data,
  output logic               rx_valid,
  output logic               frame_err
`ifdef SPI_RESPONDER_UNDERRUN_EN
  ,
  input  logic               underrun_clr,
  output logic               tx_underrun
`endif
);

  localparam int unsigned FLUSH_W = 3;

  logic sclk_s, sclk_rise, sclk_fall;
  logic cs_s, cs_rise, cs_fall;
  logic mosi_s;
  logic [SYNC_STAGES-1:0] mosi_sync_q;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
    .clk    (clk),
    .rst    (rst),
    .d_i    (sclk),
    .sync_o (sclk_s),
    .rise_c (sclk_rise),
    .fall_c (sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk    (clk),
    .rst    (rst),
    .d_i    (cs),
    .sync_o (cs_s),
    .rise_c (cs_rise),
    .fall_c (cs_fall)
  );

  // Same depth as the sclk chain so mosi is sampled in step with the detected edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) mosi_sync_q <= '0;
    else     mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
  end
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // After reset, frames are accepted only once an idle bus has been seen through flushed synchronizers.
  logic [FLUSH_W-1:0] flush_q;
  logic               flush_done;
  logic               armed_q;

  assign flush_done = (flush_q == FLUSH_W'(SYNC_STAGES));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_q <= '0;
      armed_q <= 1'b0;
    end else begin
      if (!flush_done) flush_q <= flush_q + FLUSH_W'(1);
      if (flush_done && cs_s && !sclk_s) armed_q <= 1'b1;
    end
  end

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FRAME_W-1:0] rx_sh_q, rx_sh_d;
  logic [FRAME_W-1:0] tx_sh_q, tx_sh_d;
  logic [FRAME_W-1:0] buf_q, buf_d;
  logic [FRAME_W-1:0] rx_data_q, rx_data_d;
  logic               tx_ready_q, tx_ready_d;
  logic               miso_q, miso_d;
  logic               rx_valid_q, rx_valid_d;
  logic               frame_err_q, frame_err_d;
  logic               start_empty;
  logic               tx_hs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rx_sh_q     <= '0;
      tx_sh_q     <= '0;
      buf_q       <= '0;
      rx_data_q   <= '0;
      tx_ready_q  <= 1'b1;
      miso_q      <= 1'b0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rx_sh_q     <= rx_sh_d;
      tx_sh_q     <= tx_sh_d;
      buf_q       <= buf_d;
      rx_data_q   <= rx_data_d;
      tx_ready_q  <= tx_ready_d;
      miso_q      <= miso_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rx_sh_d     = rx_sh_q;
    tx_sh_d     = tx_sh_q;
    buf_d       = buf_q;
    rx_data_d   = rx_data_q;
    tx_ready_d  = tx_ready_q;
    miso_d      = miso_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    start_empty = 1'b0;
    tx_hs       = tx_valid && tx_ready_q;

    if (tx_hs) begin
      buf_d      = tx_data;
      tx_ready_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        miso_d = 1'b0;
        if (cs_fall && armed_q) begin
          state_d = SHIFT;
          cnt_d   = '0;
          rx_sh_d = '0;
          // A word arriving on the start cycle bypasses the buffer.
          if (!tx_ready_q) begin
            tx_sh_d    = buf_q;
            tx_ready_d = 1'b1;
          end else if (tx_hs) begin
            tx_sh_d    = tx_data;
            tx_ready_d = 1'b1;
          end else begin
            tx_sh_d     = IDLE_WORD;
            start_empty = 1'b1;
          end
          miso_d = tx_sh_d[0];
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_d     = IDLE;
          frame_err_d = 1'b1;
          miso_d      = 1'b0;
          cnt_d       = '0;
        end else if (sclk_rise) begin
          rx_sh_d = {mosi_s, rx_sh_q[FRAME_W-1:1]};
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(FRAME_W - 1)) begin
            state_d    = HOLD;
            rx_data_d  = rx_sh_d;
            rx_valid_d = 1'b1;
            miso_d     = 1'b0;
          end
        end else if (sclk_fall) begin
          tx_sh_d = {1'b0, tx_sh_q[FRAME_W-1:1]};
          miso_d  = tx_sh_q[1];
        end
      end
      HOLD: begin
        miso_d = 1'b0;
        if (cs_rise) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        miso_d  = 1'b0;
      end
    endcase
  end

  assign miso      = miso_q;
  assign tx_ready  = tx_ready_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;

`ifdef SPI_RESPONDER_UNDERRUN_EN
  logic underrun_q;

  // Set wins over a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               underrun_q <= 1'b0;
    else if (start_empty)  underrun_q <= 1'b1;
    else if (underrun_clr) underrun_q <= 1'b0;
  end

  assign tx_underrun = underrun_q;
`endif

endmodule

// File: tb/tb_spi_responder.sv
// Self-checking bench for spi_responder: scoreboarded rx words, inline miso/flag checks.
`timescale 1ns/1ps
module tb_spi_responder;

  localparam int unsigned HALF = 63;

  logic        clk = 1'b0;
  logic        rst;
  logic        sclk;
  logic        cs;
  logic        mosi;
  logic        miso;
  logic [11:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [11:0] rx_data;
  logic        rx_valid;
  logic        frame_err;
`ifdef SPI_RESPONDER_UNDERRUN_EN
  logic        underrun_clr;
  logic        tx_underrun;
`endif

  int errors = 0;
  int checks = 0;
  int rxv_cnt = 0;
  int fe_cnt = 0;
  logic [11:0] exp_rx[$];
  logic [11:0] mon_exp;

  spi_responder dut (
    .clk       (clk),
    .rst       (rst),
    .sclk      (sclk),
    .cs        (cs),
    .mosi      (mosi),
    .miso      (miso),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err)
`ifdef SPI_RESPONDER_UNDERRUN_EN
    ,
    .underrun_clr (underrun_clr),
    .tx_underrun  (tx_underrun)
`endif
  );

  always #5 clk = ~clk;

  // Scoreboard: every rx_valid pulse must match the next queued word.
  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      rxv_cnt++;
      checks++;
      if (exp_rx.size() == 0) begin
        errors++;
        $display("FAIL rx_unexpected got=%h", rx_data);
      end else begin
        mon_exp = exp_rx.pop_front();
        if (rx_data !== mon_exp) begin
          errors++;
          $display("FAIL rx_word got=%h exp=%h", rx_data, mon_exp);
        end
      end
    end
    if (frame_err === 1'b1) fe_cnt++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tx_push(input logic [11:0] w);
    int n;
    n = 0;
    @(negedge clk);
    while (tx_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL tx_push_timeout tx_ready=%b exp=1", tx_ready);
    end
    tx_data  = w;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic spi_frame(input logic [11:0] mw, input int nbits,
                           output logic [11:0] mr, output logic extra_bad);
    mr = '0;
    extra_bad = 1'b0;
    cs = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      mosi = (i < 12) ? mw[4'(i)] : 1'b1;
      #HALF;
      if (i < 12) mr[4'(i)] = miso;
      else if (miso !== 1'b0) extra_bad = 1'b1;
      sclk = 1'b1;
      #HALF;
      sclk = 1'b0;
    end
    #HALF;
    cs = 1'b1;
    mosi = 1'b0;
    #(4*HALF);
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    sclk = 1'b0;
    cs = 1'b1;
    mosi = 1'b0;
    tx_data = '0;
    tx_valid = 1'b0;
`ifdef SPI_RESPONDER_UNDERRUN_EN
    underrun_clr = 1'b0;
`endif
    repeat (3) @(negedge clk);
    checks++; if (miso !== 1'b0)      begin errors++; $display("FAIL reset_miso got=%b exp=0", miso); end
    checks++; if (rx_data !== 12'h000) begin errors++; $display("FAIL reset_rx_data got=%h exp=000", rx_data); end
    checks++; if (rx_valid !== 1'b0)  begin errors++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
    checks++; if (tx_ready !== 1'b1)  begin errors++; $display("FAIL reset_tx_ready got=%b exp=1", tx_ready); end
    rst = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_basic;
    logic [11:0] mr;
    logic xb;
    int rv0, fe0;
    tx_push(12'hA5C);
    checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL basic_buf_full got=%b exp=0", tx_ready); end
`ifdef SPI_RESPONDER_UNDERRUN_EN
    checks++; if (tx_underrun !== 1'b0) begin errors++; $display("FAIL basic_underrun got=%b exp=0", tx_underrun); end
`endif
    rv0 = rxv_cnt; fe0 = fe_cnt;
    exp_rx.push_back(12'h3C9);
    spi_frame(12'h3C9, 12, mr, xb);
    checks++; if (mr !== 12'hA5C) begin errors++; $display("FAIL basic_miso got=%h exp=a5c", mr); end
    checks++; if (rxv_cnt - rv0 != 1) begin errors++; $display("FAIL basic_rx_pulses got=%0d exp=1", rxv_cnt - rv0); end
    checks++; if (fe_cnt != fe0) begin errors++; $display("FAIL basic_frame_err got=%0d exp=0", fe_cnt - fe0); end
    checks++; if (exp_rx.size() != 0) begin errors++; $display("FAIL basic_rx_missing pending=%0d exp=0", exp_rx.size()); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL basic_tx_ready got=%b exp=1", tx_ready); end
  endtask

  task automatic test_idle_word;
    logic [11:0] mr;
    logic xb;
    exp_rx.push_back(12'h5A3);
    spi_frame(12'h5A3, 12, mr, xb);
    checks++; if (mr !== 12'h000) begin errors++; $display("FAIL idle_word_miso got=%h exp=000", mr); end
    checks++; if (exp_rx.size() != 0) begin errors++; $display("FAIL idle_rx_missing pending=%0d exp=0", exp_rx.size()); end
`ifdef SPI_RESPONDER_UNDERRUN_EN
    checks++; if (tx_underrun !== 1'b1) begin errors++; $display("FAIL underrun_set got=%b exp=1", tx_underrun); end
    repeat (3) @(negedge clk);
    checks++; if (tx_underrun !== 1'b1) begin errors++; $display("FAIL underrun_sticky got=%b exp=1", tx_underrun); end
    underrun_clr = 1'b1;
    @(negedge clk);
    underrun_clr = 1'b0;
    checks++; if (tx_underrun !== 1'b0) begin errors++; $display("FAIL underrun_clr got=%b exp=0", tx_underrun); end
`endif
  endtask

  task automatic test_abort;
    logic [11:0] mr;
    logic xb;
    int rv0, fe0;
    rv0 = rxv_cnt; fe0 = fe_cnt;
    spi_frame(12'h0F0, 5, mr, xb);
    checks++; if (fe_cnt - fe0 != 1) begin errors++; $display("FAIL abort_frame_err got=%0d exp=1", fe_cnt - fe0); end
    checks++; if (rxv_cnt != rv0) begin errors++; $display("FAIL abort_rx_valid got=%0d exp=0", rxv_cnt - rv0); end
    checks++; if (rx_data !== 12'h5A3) begin errors++; $display("FAIL abort_rx_hold got=%h exp=5a3", rx_data); end
    exp_rx.push_back(12'h6B1);
    spi_frame(12'h6B1, 12, mr, xb);
    checks++; if (rxv_cnt - rv0 != 1) begin errors++; $display("FAIL abort_next_rx got=%0d exp=1", rxv_cnt - rv0); end
    checks++; if (rx_data !== 12'h6B1) begin errors++; $display("FAIL abort_next_data got=%h exp=6b1", rx_data); end
  endtask

  task automatic test_hold_tx;
    logic [11:0] mr, mr2;
    logic xb, xb2;
    tx_push(12'h2D4);
    exp_rx.push_back(12'h4C7);
    fork
      spi_frame(12'h4C7, 12, mr, xb);
      begin
        #(HALF*8);
        tx_push(12'h111);
        checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL hold_mid_ready got=%b exp=0", tx_ready); end
      end
    join
    checks++; if (mr !== 12'h2D4) begin errors++; $display("FAIL hold_cur_miso got=%h exp=2d4", mr); end
    checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL hold_ready_kept got=%b exp=0", tx_ready); end
    exp_rx.push_back(12'h3A8);
    spi_frame(12'h3A8, 12, mr2, xb2);
    checks++; if (mr2 !== 12'h111) begin errors++; $display("FAIL hold_next_miso got=%h exp=111", mr2); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL hold_ready_free got=%b exp=1", tx_ready); end
  endtask

  task automatic test_long;
    logic [11:0] mr;
    logic xb;
    int rv0;
    tx_push(12'h35A);
    rv0 = rxv_cnt;
    exp_rx.push_back(12'h9E7);
    spi_frame(12'h9E7, 16, mr, xb);
    checks++; if (mr !== 12'h35A) begin errors++; $display("FAIL long_miso got=%h exp=35a", mr); end
    checks++; if (xb !== 1'b0) begin errors++; $display("FAIL long_extra_miso got=%b exp=0", xb); end
    checks++; if (rxv_cnt - rv0 != 1) begin errors++; $display("FAIL long_rx_pulses got=%0d exp=1", rxv_cnt - rv0); end
    checks++; if (rx_data !== 12'h9E7) begin errors++; $display("FAIL long_rx_data got=%h exp=9e7", rx_data); end
  endtask

  task automatic test_reset_midframe;
    logic [11:0] mr;
    logic xb;
    int rv0, fe0;
    tx_push(12'h777);
    rv0 = rxv_cnt; fe0 = fe_cnt;
    cs = 1'b0;
    for (int i = 0; i < 6; i++) begin
      mosi = 1'b1;
      #HALF;
      sclk = 1'b1;
      #HALF;
      sclk = 1'b0;
      if (i == 2) tx_push(12'h888);
    end
    #HALF;
    @(negedge clk);
    checks++; if (miso !== 1'b1) begin errors++; $display("FAIL mid_miso_pre got=%b exp=1", miso); end
    checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL mid_ready_pre got=%b exp=0", tx_ready); end
    rst = 1'b1;
    #1;
    checks++; if (miso !== 1'b0)       begin errors++; $display("FAIL rst_mid_miso got=%b exp=0", miso); end
    checks++; if (rx_data !== 12'h000) begin errors++; $display("FAIL rst_mid_rx_data got=%h exp=000", rx_data); end
    checks++; if (tx_ready !== 1'b1)   begin errors++; $display("FAIL rst_mid_tx_ready got=%b exp=1", tx_ready); end
    checks++; if (rx_valid !== 1'b0 || frame_err !== 1'b0) begin
      errors++; $display("FAIL rst_mid_pulses got=%b%b exp=00", rx_valid, frame_err);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #HALF; sclk = 1'b1; #HALF; sclk = 1'b0;
    end
    #HALF;
    cs = 1'b1;
    mosi = 1'b0;
    #(4*HALF);
    exp_rx.push_back(12'hFFF);
    spi_frame(12'hFFF, 12, mr, xb);
    checks++; if (rx_data !== 12'hFFF) begin errors++; $display("FAIL rst_next_rx got=%h exp=fff", rx_data); end
    checks++; if (mr !== 12'h000) begin errors++; $display("FAIL rst_next_miso got=%h exp=000", mr); end
    checks++; if (rxv_cnt - rv0 != 1) begin errors++; $display("FAIL rst_rx_pulses got=%0d exp=1", rxv_cnt - rv0); end
    checks++; if (fe_cnt != fe0) begin errors++; $display("FAIL rst_frame_err got=%0d exp=0", fe_cnt - fe0); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_idle_word();
    test_abort();
    test_hold_tx();
    test_long();
    test_reset_midframe();
    repeat (10) @(negedge clk);
    checks++;
    if (exp_rx.size() != 0) begin
      errors++;
      $display("FAIL rx_pending got=%0d exp=0", exp_rx.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
